// File: rtl/cp0_exc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | cp0_exc_unit : CP0 SR/Cause/EPC and exception/interrupt request (M stage)
// | rev 1.0
// +----------------------------------------------------------------------------
module cp0_exc_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          HWINT_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  input  logic [31:0]        vpc,
  input  logic               bd_in,
  input  logic [4:0]         exc_code_in,
  input  logic [HWINT_W-1:0] hw_int,
  input  logic               exl_clr,
  output logic               req,
  output logic [31:0]        handler_pc,
  output logic [31:0]        epc_out
);

  localparam logic [4:0] c_ADDR_SR    = 5'd12;
  localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] c_ADDR_EPC   = 5'd14;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic [5:0]  w_hw;
  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_pc_al;
  logic [31:0] w_epc_nxt;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // The IM/IP fields are six bits wide whatever the number of physical lines.
  generate
    if (HWINT_W >= 6) begin : g_hw_trunc
      assign w_hw = hw_int[5:0];
    end else begin : g_hw_pad
      assign w_hw = {{(6-HWINT_W){1'b0}}, hw_int};
    end
  endgenerate

  assign w_int_req = r_ie & ~r_exl & (|(r_im & w_hw));
  assign w_exc_req = ~r_exl & (exc_code_in != 5'd0);
  assign req       = w_int_req | w_exc_req;

  assign w_pc_al   = {vpc[31:2], 2'b00};
  assign w_epc_nxt = bd_in ? (w_pc_al - 32'd4) : w_pc_al;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      c_ADDR_SR:    cp0_rdata = w_sr;
      c_ADDR_CAUSE: cp0_rdata = w_cause;
      c_ADDR_EPC:   cp0_rdata = r_epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = r_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= 6'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= 6'd0;
      r_exc <= 5'd0;
      r_epc <= 32'd0;
    end else begin
      r_ip <= w_hw;
      if (req) begin
        // Taking the trap drops any same-cycle mtc0 or eret.
        r_exl <= 1'b1;
        r_bd  <= bd_in;
        r_exc <= w_int_req ? 5'd0 : exc_code_in;
        r_epc <= w_epc_nxt;
      end else begin
        if (wr_en && (cp0_addr == c_ADDR_SR)) begin
          r_im <= cp0_wdata[15:10];
          r_ie <= cp0_wdata[0];
          if (!exl_clr) begin
            r_exl <= cp0_wdata[1];
          end
        end
        if (exl_clr) begin
          r_exl <= 1'b0;
        end
        if (wr_en && (cp0_addr == c_ADDR_EPC)) begin
          r_epc <= cp0_wdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_cp0_exc_unit : directed self-checking bench for cp0_exc_unit
// | rev 1.0
// +----------------------------------------------------------------------------
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_checks   = 0;
  int n_failures = 0;

  cp0_exc_unit #(
    .HANDLER_ADDR (32'h0000_4180),
    .HWINT_W      (6)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .exl_clr     (exl_clr),
    .req         (req),
    .handler_pc  (handler_pc),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
    vpc = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
    step(); step();
    rd_check("rst_sr", 5'd12, 32'd0);
    rd_check("rst_cause", 5'd13, 32'd0);
    rd_check("rst_epc", 5'd14, 32'd0);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_epc_out", epc_out, 32'd0);
    check("handler_pc", handler_pc, 32'h0000_4180);
    reset = 1'b1;
    step();

    // Interrupt taken with zero latency, then masked by EXL.
    wr_en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    step();
    wr_en = 1'b0; hw_int = 6'b000001; vpc = 32'h3010; bd_in = 1'b0;
    #1;
    check("int_req", {31'd0, req}, 32'd1);
    step();
    rd_check("int_sr", 5'd12, 32'h0000_0403);
    rd_check("int_cause", 5'd13, 32'h0000_0400);
    rd_check("int_epc", 5'd14, 32'h0000_3010);
    check("int_req_after", {31'd0, req}, 32'd0);

    // EXL masks exceptions and interrupts; IP still follows the lines.
    exc_code_in = 5'd4; hw_int = 6'h3f;
    #1;
    check("exl_mask_req", {31'd0, req}, 32'd0);
    step();
    rd_check("exl_ip", 5'd13, 32'h0000_fc00);
    exc_code_in = 5'd0; exl_clr = 1'b1;
    #1;
    check("exl_clr_req_same", {31'd0, req}, 32'd0);
    step();
    exl_clr = 1'b0;
    #1;
    check("exl_clr_rearm", {31'd0, req}, 32'd1);
    rd_check("exl_clr_sr", 5'd12, 32'h0000_0401);
    hw_int = 6'd0;
    wr_en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0000;
    #1;
    check("ie_off_req", {31'd0, req}, 32'd0);
    step();
    wr_en = 1'b0;

    // Overflow in a delay slot.
    exc_code_in = 5'd12; vpc = 32'h3024; bd_in = 1'b1;
    #1;
    check("exc_req", {31'd0, req}, 32'd1);
    step();
    exc_code_in = 5'd0; bd_in = 1'b0;
    rd_check("exc_cause", 5'd13, 32'h8000_0030);
    rd_check("exc_epc", 5'd14, 32'h0000_3020);
    rd_check("exc_sr", 5'd12, 32'h0000_0002);

    // eret together with an SR write: EXL clears, IM/IE load.
    exl_clr = 1'b1; wr_en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403;
    step();
    exl_clr = 1'b0; wr_en = 1'b0;
    rd_check("eret_sr_write", 5'd12, 32'h0000_0401);

    // Interrupt and RI together, plus a dropped EPC write.
    hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h3100;
    wr_en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hdead_beef;
    #1;
    check("both_req", {31'd0, req}, 32'd1);
    step();
    wr_en = 1'b0; hw_int = 6'd0; exc_code_in = 5'd0;
    rd_check("both_cause", 5'd13, 32'h0000_0400);
    rd_check("both_epc", 5'd14, 32'h0000_3100);

    // Cause is read-only; EPC write is not bypassed; unmapped reads 0.
    wr_en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hffff_ffff;
    step();
    wr_en = 1'b0;
    rd_check("cause_ro", 5'd13, 32'h0000_0000);
    wr_en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3abc;
    #1;
    check("epc_no_bypass", epc_out, 32'h0000_3100);
    step();
    wr_en = 1'b0;
    check("epc_out_wr", epc_out, 32'h0000_3abc);
    rd_check("epc_rd_wr", 5'd14, 32'h0000_3abc);
    rd_check("addr7", 5'd7, 32'd0);

    // Asynchronous reset while in the handler.
    wr_en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3010;
    step();
    wr_en = 1'b0; hw_int = 6'b000001;
    rd_check("pre_rst_sr", 5'd12, 32'h0000_0403);
    reset = 1'b0;
    #1;
    rd_check("arst_sr", 5'd12, 32'd0);
    rd_check("arst_cause", 5'd13, 32'd0);
    rd_check("arst_epc", 5'd14, 32'd0);
    check("arst_epc_out", epc_out, 32'd0);
    check("arst_req", {31'd0, req}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_req", {31'd0, req}, 32'd0);
    rd_check("post_rst_ip", 5'd13, 32'h0000_0400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Coprocessor-0 exception/interrupt controller, instantiated at the M stage.
- Consumes the per-instruction exception code carried down the pipeline from the fetch/decode registers, plus the external hardware interrupt lines.
- Produces the single request that flushes the pipeline registers and redirects fetch to the handler.
- Holds the SR, Cause and EPC state, services mfc0/mtc0, and supplies EPC for eret.

Parameters:
HANDLER_ADDR, 32'h0000_4180, exception handler entry PC, driven on handler_pc
HWINT_W, 6, number of hardware interrupt lines

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
wr_en  in  1  mtc0 write strobe
cp0_addr  in  5  register select: 12=SR, 13=Cause, 14=EPC
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational
vpc  in  32  PC of the instruction currently in M
bd_in  in  1  M instruction is in a branch delay slot
exc_code_in  in  5  exception code of the M instruction; 0 = none
hw_int  in  HWINT_W  hardware interrupt lines, level-sensitive
exl_clr  in  1  eret in M
req  out  1  take exception/interrupt this cycle; flush FD/DE/EM, redirect fetch
handler_pc  out  32  constant HANDLER_ADDR
epc_out  out  32  current EPC register value

Behaviour:
- Register fields:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC: 32 bits.
- Reset (reset=0, async): SR=0, Cause=0, EPC=0. Outputs therefore read req=0, cp0_rdata=0 (any address), epc_out=0.
- Request logic (combinational, zero latency):
  - int_req = IE & ~EXL & |(IM & hw_int)
  - exc_req = ~EXL & (exc_code_in != 0)
  - req = int_req | exc_req
- On a clock edge with req=1:
  - EXL <= 1
  - BD <= bd_in
  - ExcCode <= int_req ? 0 : exc_code_in (interrupt has priority over a synchronous exception)
  - EPC <= bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}
- IP tracks the lines every cycle regardless of req/EXL: IP <= hw_int, so IP reflects the previous cycle.
- mtc0 (wr_en=1, no req):
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes EPC in full.
  - addr 13 and other addresses: ignored (Cause is read-only).
- exl_clr=1 (no req): EXL <= 0.
- Priority within one edge: req > exl_clr > wr_en.
  - With req=1, the mtc0 write and exl_clr are dropped.
  - With exl_clr=1 and an SR write in the same cycle, EXL becomes 0 while IM/IE take cp0_wdata.
- mfc0: cp0_rdata shows the registered value at cp0_addr (12/13/14); any other address returns 0. No bypass of a same-cycle write.
- While EXL=1, req stays 0 for both interrupts and exceptions (no nesting). Pending lines remain visible in IP.
- epc_out is the register value only. Downstream eret logic handles forwarding of an in-flight mtc0 EPC by stalling.
- Exception codes used: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12. Any nonzero exc_code_in is accepted verbatim.
- Reset asserted mid-handler: all state clears at once. After release, req=0 until IE and IM are set again.

Test Plan:
1. Interrupt: reset release; mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1); hw_int=6'b000001, vpc=32'h3010, bd_in=0 -> req=1 the same cycle. Next cycle: SR=32'h0000_0403, Cause[6:2]=0, IP[10]=1, EPC=32'h3010, req=0.
2. Exception in delay slot: SR IE=0; exc_code_in=12, vpc=32'h3024, bd_in=1 -> req=1. After the edge: Cause=32'h8000_0030 (plus IP), EPC=32'h3020, EXL=1.
3. Simultaneous events: IE=1, IM[10]=1, hw_int[0]=1 and exc_code_in=10 -> ExcCode=0, i.e. interrupt wins. The same cycle's wr_en to EPC with 32'hdead_beef is dropped.
4. EXL masking: EXL=1, exc_code_in=4, hw_int=6'h3f -> req=0. Then exl_clr=1 -> EXL=0, and req reasserts the next cycle if hw_int is still high.
5. mtc0/mfc0: write Cause=32'hffff_ffff -> read 13 returns the unchanged value. Write EPC=32'h0000_3abc -> epc_out=32'h0000_3abc the next cycle. Read addr 7 returns 0.
6. Async reset mid-handler: EXL=1, EPC=32'h3010; pull reset low between clock edges -> SR, Cause, EPC and epc_out read 0 before the next edge, and req=0.
